// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the ALU issue/capture controller.
//   WIDTH            datapath width in bits
//   CNT_W            shift/rotate count width
//   alu_op_t         5-bit opcode encoding (values above OpLt are illegal)
//   alu_ctrl_state_t controller FSM states
//   is_shift()       true for SHR/SHL/ROR/ROL
//   is_legal()       true for defined opcodes
package alu_pkg;

  localparam int unsigned WIDTH = 20;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [4:0] {
    OpNot = 5'd0,
    OpAnd = 5'd1,
    OpOr  = 5'd2,
    OpXor = 5'd3,
    OpShr = 5'd4,
    OpShl = 5'd5,
    OpRor = 5'd6,
    OpRol = 5'd7,
    OpInc = 5'd8,
    OpDec = 5'd9,
    OpAdd = 5'd10,
    OpAdc = 5'd11,
    OpSub = 5'd12,
    OpSbb = 5'd13,
    OpEq  = 5'd14,
    OpGt  = 5'd15,
    OpLt  = 5'd16
  } alu_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StDone
  } alu_ctrl_state_t;

  function automatic logic is_shift(alu_op_t op);
    return op inside {OpShr, OpShl, OpRor, OpRol};
  endfunction

  function automatic logic is_legal(alu_op_t op);
    return op <= OpLt;
  endfunction

endpackage

// File: rtl/alu_step.sv
// alu_step: combinational single-step ALU datapath.
// Shift/rotate opcodes move exactly one bit; multi-bit counts are iterated by the caller.
// Ports:
//   op_i      opcode
//   a_i, b_i  operands (a_i is the caller's working register for shifts)
//   carry_i   current carry flag (used by ADC/SBB, passed through for illegal ops)
//   result_o  result word
//   carry_o   carry/borrow out
//   zero_o    result == 0
//   sign_o    result MSB, or MSB of a-b for compares
module alu_step
  import alu_pkg::*;
(
  input  alu_op_t          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             sign_o
);

  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;
  logic           cmp_op;

  always_comb begin
    // Extra top bit captures carry out / unsigned borrow.
    sum_ext  = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, (op_i == OpAdc) & carry_i};
    diff_ext = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, (op_i == OpSbb) & carry_i};
    result_o = '0;
    carry_o  = carry_i;
    cmp_op   = 1'b0;
    unique case (op_i)
      OpNot: begin result_o = ~a_i;        carry_o = 1'b0; end
      OpAnd: begin result_o = a_i & b_i;   carry_o = 1'b0; end
      OpOr:  begin result_o = a_i | b_i;   carry_o = 1'b0; end
      OpXor: begin result_o = a_i ^ b_i;   carry_o = 1'b0; end
      OpShr: begin result_o = {1'b0, a_i[WIDTH-1:1]};      carry_o = a_i[0];       end
      OpShl: begin result_o = {a_i[WIDTH-2:0], 1'b0};      carry_o = a_i[WIDTH-1]; end
      OpRor: begin result_o = {a_i[0], a_i[WIDTH-1:1]};    carry_o = a_i[0];       end
      OpRol: begin result_o = {a_i[WIDTH-2:0], a_i[WIDTH-1]}; carry_o = a_i[WIDTH-1]; end
      OpInc: begin result_o = a_i + WIDTH'(1); carry_o = &a_i;         end
      OpDec: begin result_o = a_i - WIDTH'(1); carry_o = (a_i == '0);  end
      OpAdd, OpAdc: begin
        result_o = sum_ext[WIDTH-1:0];
        carry_o  = sum_ext[WIDTH];
      end
      OpSub, OpSbb: begin
        result_o = diff_ext[WIDTH-1:0];
        carry_o  = diff_ext[WIDTH];
      end
      OpEq: begin result_o = WIDTH'(a_i == b_i); carry_o = diff_ext[WIDTH]; cmp_op = 1'b1; end
      OpGt: begin result_o = WIDTH'(a_i > b_i);  carry_o = diff_ext[WIDTH]; cmp_op = 1'b1; end
      OpLt: begin result_o = WIDTH'(a_i < b_i);  carry_o = diff_ext[WIDTH]; cmp_op = 1'b1; end
      default: begin
        result_o = '0;
        carry_o  = carry_i;
      end
    endcase
    zero_o = (result_o == '0);
    sign_o = cmp_op ? diff_ext[WIDTH-1] : result_o[WIDTH-1];
  end

endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: issue/capture controller in front of the single-step ALU datapath.
// Accepts one request (valid/ready), executes it, holds the result until the consumer
// takes it (valid/ready), and owns the persistent carry/zero/sign flag register.
// Optional feature macro: ALU_CTRL_MULTISHIFT_EN
//   defined   - shifts/rotates iterate req_cnt_i single-bit steps (count 0 passes a through)
//   undefined - req_cnt_i ignored, every shift/rotate is one bit in one EXEC cycle
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   req_valid_i/req_ready_o       request handshake
//   req_op_i, req_a_i, req_b_i    opcode and operands
//   req_cnt_i                     shift/rotate count
//   rsp_valid_o/rsp_ready_i       response handshake
//   rsp_result_o                  result word
//   flag_c_o, flag_z_o, flag_s_o  flag register
module alu_ctrl
  import alu_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [4:0]       req_op_i,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  input  logic [CNT_W-1:0] req_cnt_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic             flag_c_o,
  output logic             flag_z_o,
  output logic             flag_s_o
);

  alu_ctrl_state_t  state_q, state_d;
  alu_op_t          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             flag_c_q, flag_c_d;
  logic             flag_z_q, flag_z_d;
  logic             flag_s_q, flag_s_d;

  logic             shift_op;
  logic             exec_last;
  logic [WIDTH-1:0] step_result;
  logic             step_carry;
  logic             step_zero;
  logic             step_sign;

  assign shift_op = is_shift(op_q);

`ifdef ALU_CTRL_MULTISHIFT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_zero;

  assign cnt_zero  = (cnt_q == '0);
  // Counts 0 and 1 both finish after a single EXEC cycle.
  assign exec_last = !shift_op || (cnt_q <= CNT_W'(1));
`else
  logic unused_cnt;

  assign unused_cnt = ^req_cnt_i;
  assign exec_last  = 1'b1;
`endif

  alu_step u_alu_step (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .carry_i  (flag_c_q),
    .result_o (step_result),
    .carry_o  (step_carry),
    .zero_o   (step_zero),
    .sign_o   (step_sign)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid_i) state_d = StExec;
      StExec:  if (exec_last)   state_d = StDone;
      StDone:  if (rsp_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    req_ready_o  = (state_q == StIdle);
    rsp_valid_o  = (state_q == StDone);
    rsp_result_o = result_q;
    flag_c_o     = flag_c_q;
    flag_z_o     = flag_z_q;
    flag_s_o     = flag_s_q;
  end

  // Operand, working, result and flag next-state.
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    flag_s_d = flag_s_q;
`ifdef ALU_CTRL_MULTISHIFT_EN
    cnt_d    = cnt_q;
`endif
    if (state_q == StIdle && req_valid_i) begin
      op_d = alu_op_t'(req_op_i);
      a_d  = req_a_i;
      b_d  = req_b_i;
`ifdef ALU_CTRL_MULTISHIFT_EN
      cnt_d = req_cnt_i;
`endif
    end else if (state_q == StExec) begin
`ifdef ALU_CTRL_MULTISHIFT_EN
      if (shift_op && !cnt_zero) begin
        a_d   = step_result;
        cnt_d = cnt_q - CNT_W'(1);
      end
`endif
      if (exec_last) begin
        if (!is_legal(op_q)) begin
          result_d = '0;
`ifdef ALU_CTRL_MULTISHIFT_EN
        end else if (shift_op && cnt_zero) begin
          // Zero count passes a through with carry untouched.
          result_d = a_q;
          flag_z_d = (a_q == '0);
          flag_s_d = a_q[WIDTH-1];
`endif
        end else begin
          result_d = step_result;
          flag_c_d = step_carry;
          flag_z_d = step_zero;
          flag_s_d = step_sign;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q     <= OpNot;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_s_q <= 1'b0;
`ifdef ALU_CTRL_MULTISHIFT_EN
      cnt_q    <= '0;
`endif
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
      flag_s_q <= flag_s_d;
`ifdef ALU_CTRL_MULTISHIFT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed self-checking bench for alu_ctrl.
// Flags are compared as {C, Z, S}. Latency is the number of rising edges after the
// accepting edge at which rsp_valid_o is first sampled high.
module tb_alu_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_op = 5'd0;
  logic [19:0] req_a = '0;
  logic [19:0] req_b = '0;
  logic [4:0]  req_cnt = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [19:0] rsp_result;
  logic        flag_c, flag_z, flag_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_ctrl u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_i     (req_op),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_cnt_i    (req_cnt),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_result_o (rsp_result),
    .flag_c_o     (flag_c),
    .flag_z_o     (flag_z),
    .flag_s_o     (flag_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a request at the negedge and let the next rising edge accept it.
  task automatic issue(input string tag, input logic [4:0] op, input logic [19:0] a,
                       input logic [19:0] b, input logic [4:0] cnt);
    @(negedge clk);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_cnt   = cnt;
    req_valid = 1'b1;
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic [19:0] a,
                        input logic [19:0] b, input logic [4:0] cnt,
                        input logic [19:0] exp_res, input logic [2:0] exp_flags,
                        input int exp_lat);
    int lat;
    issue(tag, op, a, b, cnt);
    wait_rsp(lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_res"}, 32'(rsp_result), 32'(exp_res));
    check_eq({tag, "_flags"}, 32'({flag_c, flag_z, flag_s}), 32'(exp_flags));
    take_rsp();
  endtask

  initial begin
    int lat;

    // Reset state.
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_result", 32'(rsp_result), 32'd0);
    check_eq("rst_flags", 32'({flag_c, flag_z, flag_s}), 32'd0);
    rst = 1'b0;

    //      tag      op      a         b         cnt    result    {C,Z,S} lat
    run_op("add",   5'd10, 20'hFFFFF, 20'h00001, 5'd0,  20'h00000, 3'b110, 2);
    run_op("adc",   5'd11, 20'h00005, 20'h00006, 5'd0,  20'h0000C, 3'b000, 2);
    run_op("sub",   5'd12, 20'h00003, 20'h00005, 5'd0,  20'hFFFFE, 3'b101, 2);
    run_op("illeg", 5'd17, 20'h00003, 20'h00005, 5'd0,  20'h00000, 3'b101, 2);
    run_op("lt",    5'd16, 20'h00003, 20'h00005, 5'd0,  20'h00001, 3'b101, 2);
    run_op("eq",    5'd14, 20'h00007, 20'h00007, 5'd0,  20'h00001, 3'b000, 2);
    run_op("gt",    5'd15, 20'h00003, 20'h00005, 5'd0,  20'h00000, 3'b111, 2);
    run_op("sbb",   5'd13, 20'h0000A, 20'h00003, 5'd0,  20'h00006, 3'b000, 2);
    run_op("inc",   5'd8,  20'hFFFFF, 20'h00000, 5'd0,  20'h00000, 3'b110, 2);
    run_op("dec",   5'd9,  20'h00000, 20'h00000, 5'd0,  20'hFFFFF, 3'b101, 2);
    run_op("xor",   5'd3,  20'hFFFFF, 20'h0F0F0, 5'd0,  20'hF0F0F, 3'b001, 2);
    run_op("not",   5'd0,  20'h00000, 20'h00000, 5'd0,  20'hFFFFF, 3'b001, 2);

`ifdef ALU_CTRL_MULTISHIFT_EN
    run_op("shl19", 5'd5,  20'h00001, 20'h00000, 5'd19, 20'h80000, 3'b001, 20);
    run_op("shl20", 5'd5,  20'h00001, 20'h00000, 5'd20, 20'h00000, 3'b110, 21);
    run_op("shr0",  5'd4,  20'h12345, 20'h00000, 5'd0,  20'h12345, 3'b100, 2);
    run_op("rol7",  5'd7,  20'h80000, 20'h00000, 5'd7,  20'h00040, 3'b000, 8);
    run_op("ror2",  5'd6,  20'h00003, 20'h00000, 5'd2,  20'hC0000, 3'b101, 3);
    run_op("shr25", 5'd4,  20'h80000, 20'h00000, 5'd25, 20'h00000, 3'b010, 26);
`else
    run_op("rol7",  5'd7,  20'h80000, 20'h00000, 5'd7,  20'h00001, 3'b100, 2);
    run_op("shl19", 5'd5,  20'h00001, 20'h00000, 5'd19, 20'h00002, 3'b000, 2);
    run_op("shr1",  5'd4,  20'h00001, 20'h00000, 5'd3,  20'h00000, 3'b110, 2);
    run_op("ror5",  5'd6,  20'h00001, 20'h00000, 5'd5,  20'h80000, 3'b101, 2);
    run_op("shl0",  5'd5,  20'h80000, 20'h00000, 5'd0,  20'h00000, 3'b110, 2);
`endif

    // Back-pressure: AND result must hold while a competing request is ignored.
    issue("and", 5'd1, 20'hF0F0F, 20'h0FF0F, 5'd0);
    wait_rsp(lat);
    check_eq("and_lat", 32'(lat), 32'd2);
    req_op    = 5'd2;
    req_a     = 20'hFFFFF;
    req_b     = 20'hFFFFF;
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check_eq("hold_res", 32'(rsp_result), 32'h00F0F);
      check_eq("hold_flags", 32'({flag_c, flag_z, flag_s}), 32'd0);
      check_eq("hold_ready", 32'(req_ready), 32'd0);
      check_eq("hold_valid", 32'(rsp_valid), 32'd1);
      @(negedge clk);
    end
    req_valid = 1'b0;
    take_rsp();
    repeat (2) begin
      @(negedge clk);
      check_eq("post_hold_valid", 32'(rsp_valid), 32'd0);
      check_eq("post_hold_res", 32'(rsp_result), 32'h00F0F);
    end

    // Load non-zero result/flags, then reset mid-rotate.
    run_op("dec2", 5'd9, 20'h00000, 20'h00000, 5'd0, 20'hFFFFF, 3'b101, 2);
    issue("ror_rst", 5'd6, 20'h12345, 20'h00000, 5'd10);
`ifdef ALU_CTRL_MULTISHIFT_EN
    repeat (3) @(posedge clk);
`endif
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("arst_ready", 32'(req_ready), 32'd1);
    check_eq("arst_valid", 32'(rsp_valid), 32'd0);
    check_eq("arst_result", 32'(rsp_result), 32'd0);
    check_eq("arst_flags", 32'({flag_c, flag_z, flag_s}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("or",  5'd2,  20'h00F00, 20'h000F0, 5'd0, 20'h00FF0, 3'b000, 2);
    run_op("adc2", 5'd11, 20'h00001, 20'h00001, 5'd0, 20'h00002, 3'b000, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
